encoder_seq: RTL and testbench
==============================

// Module: encoder_seq
// PURPOSE
//  Sequential inverse of the 2-to-4 enable decoder: takes an N-line input vector and emits, one per
//  handshake, the binary index of every set line, lowest index first. Sits between line-level
//  request/flag sources and index-consuming logic (mux selects, decoder inputs). Valid/ready on
//  both sides; one vector is processed at a time.
// PARAMETERS
//  N   4             number of input lines; N >= 2
//  W   $clog2(N)     index width (derived localparam, not overridable)
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    asynchronous active-low reset
//  en         in   1    encoder enable, sampled with the input handshake
//  in_valid   in   1    d is valid
//  in_ready   out  1    block can accept a vector (high only in IDLE)
//  d          in   N    input line vector
//  out_valid  out  1    y/last are valid
//  out_ready  in   1    consumer accepts y this cycle
//  y          out  W    binary index of the lowest pending set line
//  last       out  1    y is the final index of the current vector
// BEHAVIOUR
//  - Reset (rst_n low, async, no clock needed): state=IDLE, pending=0, out_valid=0, y=0, last=0;
//    in_ready=1 (decoded from state). Reset mid-vector discards all pending indices.
//  - State machine: IDLE, EMIT. Registers: state, pending[N-1:0].
//  - IDLE: in_ready=1, out_valid=0, y=0, last=0. Input handshake = in_valid & in_ready at a rising edge.
//    en=1 and d!=0: pending<=d, state<=EMIT. en=0 or d==0: vector accepted and dropped, stay IDLE,
//    nothing emitted.
//  - EMIT: in_ready=0, out_valid=1; y = index of lowest set bit of pending; last=1 iff exactly one bit
//    of pending is set. y/last derive only from registered pending, never from d.
//  - On out_valid & out_ready: clear that bit in pending; if last, state<=IDLE. Otherwise stay in EMIT
//    and present the next index in the following cycle.
//  - Latency: out_valid rises the cycle after the input handshake. A vector with k set bits and
//    out_ready held high emits k indices in k consecutive cycles; in_ready returns high the cycle
//    after the last output handshake. Throughput per vector is therefore k+1 cycles.
//  - Backpressure: while out_ready=0, y, last and out_valid are held stable; pending does not change.
//  - Input side is ignored outside IDLE: in_valid, d and en have no effect in EMIT.
//  - Boundary: all-ones vector emits 0..N-1 in order with last only on N-1. A single-bit vector
//    emits one index with last=1. Index N-1 must encode in full W bits with no truncation.
//  - en is not sampled while in EMIT; clearing en mid-vector does not abort emission.
// TESTING
//  1. Assert rst_n=0 mid-run -> immediately out_valid=0, y=0, last=0, in_ready=1.
//  2. en=1, d=4'b1010, out_ready=1 -> y=1/last=0 then y=3/last=1 on consecutive cycles;
//     in_ready=1 the following cycle.
//  3. en=1, d=4'b0111, out_ready=0 for 3 cycles -> y=0, last=0, out_valid=1 held stable;
//     then out_ready=1 -> y=0,1,2 with last on 2.
//  4. en=0, d=4'b1111, then en=1, d=4'b0000 -> both accepted (in_ready stays 1), out_valid never rises.
//  5. d=4'b1111, pulse rst_n low after the y=0 handshake -> outputs cleared; next vector d=4'b0100
//     -> a single y=2, last=1.
//  6. N=8, d=8'h81 -> y=0/last=0 then y=7/last=1. Repeat test 2 with in_valid held high in EMIT
//     and d changing -> output sequence unchanged.

Source files
------------

// File: rtl/encoder_seq.sv
// Sequential priority encoder: captures an N-line vector and emits the index of each set line,
// lowest first, one per output handshake. Latency 1 cycle; output held stable under backpressure.
module encoder_seq #(
   parameter  int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] d,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] y,
   output logic         last
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_EMIT = 1'b1;

   logic [0:0]   state_q, state_d;
   logic [N-1:0] pending_q, pending_d;

   logic [W-1:0] low_idx;
   logic [N-1:0] low_onehot;
   logic         single_bit;

   // Descending scan so the lowest set bit is the final assignment.
   always_comb begin
      low_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            low_idx = W'(i);
         end
      end
   end

   assign low_onehot = N'(1) << low_idx;
   assign single_bit = (pending_q != '0) && ((pending_q & (pending_q - N'(1))) == '0);

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      case (state_q)
         ST_IDLE: begin
            // Disabled or empty vectors are consumed without producing output.
            if (in_valid && en && (d != '0)) begin
               pending_d = d;
               state_d   = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (out_ready) begin
               pending_d = pending_q & ~low_onehot;
               if (single_bit) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d   = ST_IDLE;
            pending_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_EMIT);
   assign y         = out_valid ? low_idx : '0;
   assign last      = out_valid & single_bit;

endmodule

// File: tb/tb_encoder_seq.sv
// Directed bench for encoder_seq (N=4 and N=8 instances) with a queue-based output scoreboard.
module tb_encoder_seq;

   typedef struct {
      int y;
      bit last;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic       en4 = 1'b0, in_valid4 = 1'b0, out_ready4 = 1'b0;
   logic [3:0] d4 = '0;
   logic       in_ready4, out_valid4, last4;
   logic [1:0] y4;

   logic       en8 = 1'b0, in_valid8 = 1'b0, out_ready8 = 1'b0;
   logic [7:0] d8 = '0;
   logic       in_ready8, out_valid8, last8;
   logic [2:0] y8;

   int checks = 0;
   int errors = 0;
   exp_t q4[$];
   exp_t q8[$];

   always #5 clk = ~clk;

   encoder_seq #(.N(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .en(en4), .in_valid(in_valid4), .in_ready(in_ready4),
      .d(d4), .out_valid(out_valid4), .out_ready(out_ready4), .y(y4), .last(last4)
   );

   encoder_seq #(.N(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .en(en8), .in_valid(in_valid8), .in_ready(in_ready8),
      .d(d8), .out_valid(out_valid8), .out_ready(out_ready8), .y(y8), .last(last8)
   );

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic push4(input int yv, input bit lv);
      exp_t e;
      e.y = yv;
      e.last = lv;
      q4.push_back(e);
   endtask

   task automatic push8(input int yv, input bit lv);
      exp_t e;
      e.y = yv;
      e.last = lv;
      q8.push_back(e);
   endtask

   // Output monitor: a handshake seen mid-cycle completes at the next rising edge.
   always @(negedge clk) begin
      if (rst_n && out_valid4 && out_ready4) begin
         if (q4.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL n4_unexpected: got y=%0d last=%0d expected no output", y4, last4);
         end else begin
            exp_t e;
            e = q4.pop_front();
            check("n4_y", int'(y4), e.y);
            check("n4_last", int'(last4), int'(e.last));
         end
      end
      if (rst_n && out_valid8 && out_ready8) begin
         if (q8.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL n8_unexpected: got y=%0d last=%0d expected no output", y8, last8);
         end else begin
            exp_t e;
            e = q8.pop_front();
            check("n8_y", int'(y8), e.y);
            check("n8_last", int'(last8), int'(e.last));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one vector on the N=4 port and hold it for exactly one accepted handshake.
   task automatic send4(input logic [3:0] dv, input logic ev);
      int n;
      n = 0;
      while (!in_ready4 && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready4) begin
         checks++;
         errors++;
         $display("FAIL n4_in_ready_timeout: got 0 expected 1");
      end
      d4 = dv;
      en4 = ev;
      in_valid4 = 1'b1;
      tick();
      in_valid4 = 1'b0;
   endtask

   task automatic wait_idle4(input string name);
      int n;
      n = 0;
      while (!in_ready4 && n < 50) begin
         tick();
         n++;
      end
      check(name, int'(in_ready4), 1);
   endtask

   initial begin
      // Reset state
      #2;
      check("rst_in_ready", int'(in_ready4), 1);
      check("rst_out_valid", int'(out_valid4), 0);
      check("rst_y", int'(y4), 0);
      check("rst_last", int'(last4), 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // 1010 with the consumer always ready: indices 1 then 3, idle one cycle after.
      out_ready4 = 1'b1;
      push4(1, 1'b0);
      push4(3, 1'b1);
      send4(4'b1010, 1'b1);
      check("t2_out_valid_rise", int'(out_valid4), 1);
      check("t2_in_ready_low", int'(in_ready4), 0);
      tick();
      tick();
      check("t2_in_ready_back", int'(in_ready4), 1);
      check("t2_out_valid_fall", int'(out_valid4), 0);

      // 0111 under three cycles of backpressure.
      out_ready4 = 1'b0;
      push4(0, 1'b0);
      push4(1, 1'b0);
      push4(2, 1'b1);
      send4(4'b0111, 1'b1);
      for (int i = 0; i < 3; i++) begin
         check("t3_hold_valid", int'(out_valid4), 1);
         check("t3_hold_y", int'(y4), 0);
         check("t3_hold_last", int'(last4), 0);
         tick();
      end
      out_ready4 = 1'b1;
      tick();
      tick();
      tick();
      check("t3_in_ready_back", int'(in_ready4), 1);

      // Disabled and empty vectors are swallowed.
      send4(4'b1111, 1'b0);
      check("t4_en0_in_ready", int'(in_ready4), 1);
      check("t4_en0_no_valid", int'(out_valid4), 0);
      send4(4'b0000, 1'b1);
      check("t4_zero_in_ready", int'(in_ready4), 1);
      check("t4_zero_no_valid", int'(out_valid4), 0);
      tick();
      check("t4_still_no_valid", int'(out_valid4), 0);

      // Reset mid-vector after the first index is taken.
      push4(0, 1'b0);
      send4(4'b1111, 1'b1);
      tick();
      rst_n = 1'b0;
      #1;
      check("t5_rst_out_valid", int'(out_valid4), 0);
      check("t5_rst_y", int'(y4), 0);
      check("t5_rst_last", int'(last4), 0);
      check("t5_rst_in_ready", int'(in_ready4), 1);
      #1;
      rst_n = 1'b1;
      tick();
      push4(2, 1'b1);
      send4(4'b0100, 1'b1);
      check("t5_single_valid", int'(out_valid4), 1);
      tick();
      check("t5_single_done", int'(in_ready4), 1);

      // N=8: index 7 needs the full three bits.
      out_ready8 = 1'b1;
      push8(0, 1'b0);
      push8(7, 1'b1);
      d8 = 8'h81;
      en8 = 1'b1;
      in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      tick();
      tick();
      check("t6_n8_idle", int'(in_ready8), 1);

      // Input side changes while emitting must not disturb the sequence.
      push4(1, 1'b0);
      push4(3, 1'b1);
      wait_idle4("t6_pre_idle");
      d4 = 4'b1010;
      en4 = 1'b1;
      in_valid4 = 1'b1;
      tick();
      d4 = 4'b1111;
      en4 = 1'b0;
      tick();
      d4 = 4'b0101;
      in_valid4 = 1'b0;
      tick();
      check("t6_hold_idle", int'(in_ready4), 1);
      check("t6_hold_no_valid", int'(out_valid4), 0);

      repeat (4) tick();
      check("n4_queue_drained", q4.size(), 0);
      check("n8_queue_drained", q8.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
